neuron_mac_sequencer: RTL and testbench

NEURON_MAC_SEQUENCER -- requirements
Module: neuron_mac_sequencer

---
 rtl/neuron_pkg.sv | 16 +
 rtl/neuron_saturate.sv | 33 +++
 rtl/neuron_mac_sequencer.sv | 131 +++++++++++++
 tb/tb_neuron_mac_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types for the neuron MAC sequencer: FSM state encoding and accumulator sizing.
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_BIAS  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Full product width plus enough headroom to sum n_inputs products without overflow.
  function automatic int acc_w(input int width, input int n_inputs);
    return 2 * width + $clog2(n_inputs + 1);
  endfunction

endpackage

// File: rtl/neuron_saturate.sv
// Fixed-point rescale of the biased sum: arithmetic shift, optional ReLU, clamp to WIDTH.
// Purely combinational, no handshake.
module neuron_saturate #(
  parameter int IN_W      = 19,
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 4,
  parameter int RELU      = 0
) (
  input  logic signed [IN_W-1:0]  sum_i,
  output logic signed [WIDTH-1:0] res_o
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;
  logic signed [IN_W-1:0] relu_v;
  logic signed [IN_W-1:0] clipped;

  always_comb begin
    shifted = sum_i >>> FRAC_BITS;
    relu_v  = ((RELU != 0) && shifted[IN_W-1]) ? '0 : shifted;
    if (relu_v > MAX_V) begin
      clipped = MAX_V;
    end else if (relu_v < MIN_V) begin
      clipped = MIN_V;
    end else begin
      clipped = relu_v;
    end
    res_o = clipped[WIDTH-1:0];
  end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Single neuron: streams N_INPUTS beats through a MAC against an external 1-cycle ROM, adds bias, rescales.
// Result valid 3 cycles after the last beat; no new beats are taken until the result is handed off.
module neuron_mac_sequencer
  import neuron_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int WIDTH     = 8,
  parameter int N_INPUTS  = 3,
  parameter int FRAC_BITS = 4,
  parameter int RELU      = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic signed [WIDTH-1:0] data_i,
  output logic        [DEPTH-1:0] rom_addr_o,
  input  logic signed [WIDTH-1:0] rom_data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic signed [WIDTH-1:0] data_o
);

  localparam int ACC_W = acc_w(WIDTH, N_INPUTS);
  localparam int SUM_W = ACC_W + 1;
  localparam logic [DEPTH-1:0] LAST_IDX  = DEPTH'(N_INPUTS - 1);
  localparam logic [DEPTH-1:0] BIAS_ADDR = DEPTH'(N_INPUTS);

  state_e                   state_q, state_d;
  logic [DEPTH-1:0]         count_q, count_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [WIDTH-1:0]  dreg_q, dreg_d;
  logic                     s2_vld_q, s2_vld_d;
  logic signed [WIDTH-1:0]  dout_q, dout_d;
  logic                     vout_q, vout_d;

  logic                     accept;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]  acc_mac;
  logic signed [SUM_W-1:0]  biased_sum;
  logic signed [WIDTH-1:0]  sat_res;

  // Outputs are gated by reset so the ROM and upstream see an idle block while it is held.
  assign ready_o = reset_i && (state_q == ST_ACC);
  assign accept  = valid_i && ready_o;
  assign valid_o = vout_q;
  assign data_o  = dout_q;

  always_comb begin
    rom_addr_o = '0;
    if (reset_i) begin
      case (state_q)
        ST_ACC:            rom_addr_o = count_q;
        ST_FLUSH, ST_BIAS: rom_addr_o = BIAS_ADDR;
        default:           rom_addr_o = '0;
      endcase
    end
  end

  // rom_data_i lags the address by one cycle, so it pairs with the registered sample.
  assign prod       = (2*WIDTH)'(dreg_q) * (2*WIDTH)'(rom_data_i);
  assign acc_mac    = s2_vld_q ? (acc_q + ACC_W'(prod)) : acc_q;
  assign biased_sum = SUM_W'(acc_q) + (SUM_W'(rom_data_i) <<< FRAC_BITS);

  neuron_saturate #(
    .IN_W      (SUM_W),
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .RELU      (RELU)
  ) u_saturate (
    .sum_i (biased_sum),
    .res_o (sat_res)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_mac;
    dreg_d   = accept ? data_i : dreg_q;
    s2_vld_d = accept;
    dout_d   = dout_q;
    vout_d   = vout_q;
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = ST_FLUSH;
          end else begin
            count_d = count_q + DEPTH'(1);
          end
        end
      end
      ST_FLUSH: state_d = ST_BIAS;
      ST_BIAS: begin
        dout_d  = sat_res;
        vout_d  = 1'b1;
        acc_d   = '0;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (ready_i) begin
          vout_d  = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= ST_ACC;
      count_q  <= '0;
      acc_q    <= '0;
      dreg_q   <= '0;
      s2_vld_q <= 1'b0;
      dout_q   <= '0;
      vout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      dreg_q   <= dreg_d;
      s2_vld_q <= s2_vld_d;
      dout_q   <= dout_d;
      vout_q   <= vout_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Self-checking bench: two instances (RELU off/on) sharing stimulus, each with its own registered ROM model.
module tb_neuron_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b1;
  logic              valid_i = 1'b0;
  logic              ready_i = 1'b0;
  logic signed [7:0] data_i = '0;

  logic              ready_o0, ready_o1, valid_o0, valid_o1;
  logic [2:0]        addr0, addr1;
  logic signed [7:0] rd0, rd1, do0, do1;
  logic signed [7:0] rom_mem [8];

  int checks = 0;
  int failures = 0;

  neuron_mac_sequencer #(.DEPTH(3), .WIDTH(8), .N_INPUTS(3), .FRAC_BITS(4), .RELU(0)) dut0 (
    .clk_i(clk), .reset_i(rst_n), .valid_i(valid_i), .ready_o(ready_o0), .data_i(data_i),
    .rom_addr_o(addr0), .rom_data_i(rd0), .valid_o(valid_o0), .ready_i(ready_i), .data_o(do0)
  );

  neuron_mac_sequencer #(.DEPTH(3), .WIDTH(8), .N_INPUTS(3), .FRAC_BITS(4), .RELU(1)) dut1 (
    .clk_i(clk), .reset_i(rst_n), .valid_i(valid_i), .ready_o(ready_o1), .data_i(data_i),
    .rom_addr_o(addr1), .rom_data_i(rd1), .valid_o(valid_o1), .ready_i(ready_i), .data_o(do1)
  );

  always @(posedge clk) begin
    rd0 <= rom_mem[addr0];
    rd1 <= rom_mem[addr1];
  end

  // Reference: dot product in plain integers, bias scaled up, floor-shift, ReLU, clamp.
  function automatic int model(input int xv[3], input bit relu);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++) s += xv[i] * int'(rom_mem[i]);
    s += int'(rom_mem[3]) * 16;
    s = s >>> 4;
    if (relu && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic set_rom(input int w0, input int w1, input int w2, input int b);
    rom_mem[0] = 8'(w0);
    rom_mem[1] = 8'(w1);
    rom_mem[2] = 8'(w2);
    rom_mem[3] = 8'(b);
    for (int i = 4; i < 8; i++) rom_mem[i] = 8'($urandom);
  endtask

  // Sends one vector; gap bubble cycles (with junk data) between beats. ok=0 if ready never came.
  task automatic drive_vector(input int xv[3], input int gap, output bit ok);
    int n;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!ready_o0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!ready_o0) ok = 1'b0;
      valid_i = 1'b1;
      data_i  = 8'(xv[i]);
      @(negedge clk);
      valid_i = 1'b0;
      data_i  = 8'($urandom);
      if (i < 2) repeat (gap) @(negedge clk);
    end
  endtask

  // Called at the negedge after the last accept; counts negedges until valid_o (20 = timeout).
  task automatic wait_result(output int waited);
    waited = 0;
    while (!valid_o0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic consume();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ready_o0 !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready_o0); end
    checks++; if (addr0 !== 3'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", addr0); end
    checks++; if (valid_o0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o0); end
    checks++; if (do0 !== 8'sd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", do0); end
    rst_n = 1'b1;
    #1;
    checks++; if (ready_o0 !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", ready_o0); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int xv[3] = '{16, 16, 16};
    bit ok;
    int w;
    set_rom(16, 32, -16, 8);
    drive_vector(xv, 0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_ready_timeout got=0 exp=1"); end
    wait_result(w);
    checks++; if (w !== 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", w); end
    checks++; if (int'(do0) !== 40) begin failures++; $display("FAIL b2b_data got=%0d exp=40", do0); end
    consume();
    checks++; if (ready_o0 !== 1'b1 || valid_o0 !== 1'b0) begin
      failures++; $display("FAIL b2b_handoff got ready=%b valid=%b exp ready=1 valid=0", ready_o0, valid_o0);
    end
  endtask

  task automatic test_bubbles();
    int xv[3] = '{16, 16, 16};
    bit ok;
    int w;
    set_rom(16, 32, -16, 8);
    drive_vector(xv, 2, ok);
    wait_result(w);
    checks++; if (!ok || w !== 2) begin failures++; $display("FAIL bubble_latency got=%0d exp=2", w); end
    checks++; if (int'(do0) !== 40) begin failures++; $display("FAIL bubble_data got=%0d exp=40", do0); end
    consume();
  endtask

  task automatic test_saturate();
    int xp[3] = '{127, 127, 127};
    int xn[3] = '{-128, -128, -128};
    bit ok;
    int w;
    set_rom(127, 127, 127, 0);
    drive_vector(xp, 0, ok);
    wait_result(w);
    checks++; if (int'(do0) !== 127) begin failures++; $display("FAIL sat_pos_relu0 got=%0d exp=127", do0); end
    checks++; if (int'(do1) !== 127) begin failures++; $display("FAIL sat_pos_relu1 got=%0d exp=127", do1); end
    consume();
    drive_vector(xn, 0, ok);
    wait_result(w);
    checks++; if (int'(do0) !== -128) begin failures++; $display("FAIL sat_neg_relu0 got=%0d exp=-128", do0); end
    checks++; if (int'(do1) !== 0) begin failures++; $display("FAIL sat_neg_relu1 got=%0d exp=0", do1); end
    consume();
  endtask

  task automatic test_backpressure();
    int xv[3] = '{16, 16, 16};
    bit ok;
    int w;
    set_rom(16, 32, -16, 8);
    drive_vector(xv, 0, ok);
    wait_result(w);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (int'(do0) !== 40 || valid_o0 !== 1'b1 || ready_o0 !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got data=%0d valid=%b ready=%b exp data=40 valid=1 ready=0",
                 c, do0, valid_o0, ready_o0);
      end
      @(negedge clk);
    end
    consume();
    checks++; if (ready_o0 !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b exp=1", ready_o0); end
  endtask

  task automatic test_reset_mid();
    int xv[3] = '{16, 16, 16};
    bit ok;
    int w;
    set_rom(16, 32, -16, 8);
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1;
      data_i  = 8'sd100;
      @(negedge clk);
    end
    valid_i = 1'b0;
    rst_n   = 1'b0;
    #1;
    checks++; if (ready_o0 !== 1'b0 || addr0 !== 3'd0) begin
      failures++; $display("FAIL midreset_outputs got ready=%b addr=%0d exp ready=0 addr=0", ready_o0, addr0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (addr0 !== 3'd0) begin failures++; $display("FAIL midreset_index got=%0d exp=0", addr0); end
    @(negedge clk);
    drive_vector(xv, 0, ok);
    wait_result(w);
    checks++; if (int'(do0) !== 40) begin failures++; $display("FAIL midreset_data got=%0d exp=40", do0); end
    consume();
  endtask

  task automatic test_two_vectors();
    int xa[3] = '{32, -16, 48};
    int xb[3] = '{-64, 8, 16};
    bit ok;
    int w;
    set_rom(16, 32, -16, 8);
    drive_vector(xa, 0, ok);
    wait_result(w);
    checks++; if (int'(do0) !== model(xa, 1'b0)) begin failures++; $display("FAIL vec_a got=%0d exp=%0d", do0, model(xa, 1'b0)); end
    consume();
    drive_vector(xb, 0, ok);
    wait_result(w);
    checks++; if (int'(do0) !== model(xb, 1'b0)) begin failures++; $display("FAIL vec_b got=%0d exp=%0d", do0, model(xb, 1'b0)); end
    consume();
  endtask

  task automatic test_random();
    int xv[3];
    bit ok;
    int w;
    logic signed [7:0] t;
    for (int it = 0; it < 40; it++) begin
      set_rom($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      for (int i = 0; i < 3; i++) begin
        t = 8'($urandom);
        xv[i] = int'(t);
      end
      drive_vector(xv, int'($urandom_range(0, 2)), ok);
      wait_result(w);
      checks++;
      if (!ok || w !== 2 || valid_o1 !== 1'b1) begin
        failures++; $display("FAIL rand%0d_latency got=%0d exp=2", it, w);
      end
      checks++;
      if (int'(do0) !== model(xv, 1'b0)) begin
        failures++; $display("FAIL rand%0d_relu0 got=%0d exp=%0d", it, do0, model(xv, 1'b0));
      end
      checks++;
      if (int'(do1) !== model(xv, 1'b1)) begin
        failures++; $display("FAIL rand%0d_relu1 got=%0d exp=%0d", it, do1, model(xv, 1'b1));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      consume();
    end
  endtask

  initial begin
    set_rom(16, 32, -16, 8);
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    test_two_vectors();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
